// File: rtl/act_row_packer_pkg.sv
// Shared widths for the activation row packer and its helpers.
package act_row_packer_pkg;

    localparam int ACT_DATA_WIDTH = 8;
    localparam int ACT_IF_WIDTH   = 16;
    localparam int ACT_CNT_WIDTH  = 16;
    localparam int ACT_LANE_SLICE = ACT_DATA_WIDTH;
    localparam int ACT_ROW_WIDTH  = ACT_DATA_WIDTH * ACT_IF_WIDTH;

    // Width able to hold a nonzero count of 0..lanes inclusive.
    function automatic int act_nz_width(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

    function automatic int act_lane_idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/act_row_packer_popcount.sv
// Combinational count of the set bits in a row's nonzero-lane flags.
module act_popcount
    import act_row_packer_pkg::*;
#(
    parameter int  IF_WIDTH = ACT_IF_WIDTH,
    localparam int NZ_WIDTH = act_nz_width(IF_WIDTH)
)(
    input  logic [IF_WIDTH-1:0] flags,
    output logic [NZ_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < IF_WIDTH; i++) begin
            count = count + NZ_WIDTH'(flags[i]);
        end
    end

endmodule

// File: rtl/act_row_packer.sv
// Packs a stream of signed activation bytes into IF_WIDTH-lane rows with
// per-lane nonzero flags, holding one completed row while the writer is blocked.
module act_row_packer
    import act_row_packer_pkg::*;
#(
    parameter int  DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int  IF_WIDTH   = ACT_IF_WIDTH,
    parameter int  CNT_WIDTH  = ACT_CNT_WIDTH,
    localparam int NZ_WIDTH   = act_nz_width(IF_WIDTH),
    localparam int LANE_WIDTH = act_lane_idx_width(IF_WIDTH),
    localparam int ROW_WIDTH  = DATA_WIDTH * IF_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  en,
    output logic                  wr_req_act_flag,
    output logic [IF_WIDTH-1:0]   wr_data_act_flag,
    output logic                  wr_req_act,
    output logic [ROW_WIDTH-1:0]  wr_data_act,
    output logic [NZ_WIDTH-1:0]   row_nz_cnt,
    output logic [CNT_WIDTH-1:0]  row_cnt,
    output logic                  frame_done
);

    logic [LANE_WIDTH-1:0] lane_cnt_reg;
    logic                  pending_reg;
    logic                  pend_last_reg;
    logic [DATA_WIDTH-1:0] lane_buf [IF_WIDTH];
    logic [ROW_WIDTH-1:0]  pend_data_reg;
    logic [IF_WIDTH-1:0]   pend_flag_reg;

    logic                  wr_req_reg;
    logic                  frame_done_reg;
    logic [ROW_WIDTH-1:0]  wr_data_reg;
    logic [IF_WIDTH-1:0]   wr_flag_reg;
    logic [NZ_WIDTH-1:0]   nz_reg;
    logic [CNT_WIDTH-1:0]  row_cnt_reg;

    logic                  accept;
    logic                  row_done;
    logic                  issue;
    logic [DATA_WIDTH-1:0] in_stored;
    logic [ROW_WIDTH-1:0]  row_data;
    logic [IF_WIDTH-1:0]   row_flag;
    logic [ROW_WIDTH-1:0]  src_data;
    logic [IF_WIDTH-1:0]   src_flag;
    logic                  src_last;
    logic [NZ_WIDTH-1:0]   src_nz;

    assign in_ready  = reset && !pending_reg && !clear;
    assign accept    = in_valid && in_ready;
    assign in_stored = (relu_en && in_data[DATA_WIDTH-1]) ? '0 : in_data;
    assign row_done  = accept && (in_last || (lane_cnt_reg == LANE_WIDTH'(IF_WIDTH - 1)));
    // A pending row can only exist while nothing is accepted, so the two sources never collide.
    assign issue     = !clear && en && (pending_reg || row_done);

    // Completed row as seen this cycle: buffered lanes, the incoming byte, zeros beyond it.
    genvar gi;
    generate
        for (gi = 0; gi < IF_WIDTH; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_val;
            always_comb begin
                if (LANE_WIDTH'(gi) < lane_cnt_reg)
                    lane_val = lane_buf[gi];
                else if (LANE_WIDTH'(gi) == lane_cnt_reg)
                    lane_val = in_stored;
                else
                    lane_val = '0;
            end
            assign row_data[DATA_WIDTH*gi +: DATA_WIDTH] = lane_val;
            assign row_flag[gi] = |lane_val;
        end
    endgenerate

    assign src_data = pending_reg ? pend_data_reg : row_data;
    assign src_flag = pending_reg ? pend_flag_reg : row_flag;
    assign src_last = pending_reg ? pend_last_reg : in_last;

    act_popcount #(
        .IF_WIDTH (IF_WIDTH)
    ) u_popcount (
        .flags (src_flag),
        .count (src_nz)
    );

    // Row storage needs no reset: validity is tracked by lane_cnt_reg and pending_reg.
    always_ff @(posedge clk) begin
        if (accept) begin
            lane_buf[lane_cnt_reg] <= in_stored;
        end
        if (row_done && !en) begin
            pend_data_reg <= row_data;
            pend_flag_reg <= row_flag;
            pend_last_reg <= in_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt_reg   <= '0;
            pending_reg    <= 1'b0;
            wr_req_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            wr_data_reg    <= '0;
            wr_flag_reg    <= '0;
            nz_reg         <= '0;
            row_cnt_reg    <= '0;
        end else if (clear) begin
            lane_cnt_reg   <= '0;
            pending_reg    <= 1'b0;
            wr_req_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            row_cnt_reg    <= '0;
        end else begin
            wr_req_reg     <= issue;
            frame_done_reg <= issue && src_last;

            if (accept) begin
                lane_cnt_reg <= row_done ? '0 : lane_cnt_reg + LANE_WIDTH'(1);
            end

            if (row_done && !en) begin
                pending_reg <= 1'b1;
            end else if (pending_reg && en) begin
                pending_reg <= 1'b0;
            end

            // A write right after a frame end is the first row of the next frame.
            if (issue) begin
                wr_data_reg <= src_data;
                wr_flag_reg <= src_flag;
                nz_reg      <= src_nz;
                row_cnt_reg <= frame_done_reg ? CNT_WIDTH'(1) : row_cnt_reg + CNT_WIDTH'(1);
            end else if (frame_done_reg) begin
                row_cnt_reg <= '0;
            end
        end
    end

    assign wr_req_act       = wr_req_reg;
    assign wr_req_act_flag  = wr_req_reg;
    assign wr_data_act      = wr_data_reg;
    assign wr_data_act_flag = wr_flag_reg;
    assign row_nz_cnt       = nz_reg;
    assign row_cnt          = row_cnt_reg;
    assign frame_done       = frame_done_reg;

endmodule

// File: tb/tb_act_row_packer.sv
// Directed-vector bench for act_row_packer with hand-computed expected rows.
module tb_act_row_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         relu_en = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic         en = 1'b0;
    logic         wr_req_act_flag;
    logic [15:0]  wr_data_act_flag;
    logic         wr_req_act;
    logic [127:0] wr_data_act;
    logic [4:0]   row_nz_cnt;
    logic [15:0]  row_cnt;
    logic         frame_done;

    int vectors = 0;
    int miscompares = 0;
    int strobe_cnt = 0;
    int strobe_neq = 0;

    act_row_packer dut (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .relu_en          (relu_en),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
        .en               (en),
        .wr_req_act_flag  (wr_req_act_flag),
        .wr_data_act_flag (wr_data_act_flag),
        .wr_req_act       (wr_req_act),
        .wr_data_act      (wr_data_act),
        .row_nz_cnt       (row_nz_cnt),
        .row_cnt          (row_cnt),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_req_act) strobe_cnt++;
        if (wr_req_act !== wr_req_act_flag) strobe_neq++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("  ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int stall;
        int early;
        int ns;
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_req", wr_req_act, 0);
        check("rst_data", wr_data_act, 0);
        check("rst_flag", wr_data_act_flag, 0);
        check("rst_nz", row_nz_cnt, 0);
        check("rst_row_cnt", row_cnt, 0);
        check("rst_frame_done", frame_done, 0);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        step();

        // Full row of bytes 1..16, no gaps
        en = 1'b1;
        stall = 0;
        early = 0;
        for (int k = 0; k < 16; k++) begin
            if (!in_ready) stall++;
            send_byte(8'(k + 1), 1'b0);
            if (k < 15 && wr_req_act) early++;
        end
        check("t1_stall", stall, 0);
        check("t1_early_strobe", early, 0);
        check("t1_strobe", wr_req_act, 1);
        check("t1_data", wr_data_act, 128'h100F0E0D0C0B0A090807060504030201);
        check("t1_flag", wr_data_act_flag, 16'hFFFF);
        check("t1_nz", row_nz_cnt, 16);
        check("t1_row_cnt", row_cnt, 1);
        check("t1_frame_done", frame_done, 0);
        idle(1);
        check("t1_strobe_off", wr_req_act, 0);
        check("t1_data_hold", wr_data_act, 128'h100F0E0D0C0B0A090807060504030201);

        // Short frame with ReLU: 0,5,0,0,-3 (last)
        relu_en = 1'b1;
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFD, 1'b1);
        check("t2_strobe", wr_req_act, 1);
        check("t2_flag", wr_data_act_flag, 16'h0002);
        check("t2_data", wr_data_act, 128'h0500);
        check("t2_nz", row_nz_cnt, 1);
        check("t2_frame_done", frame_done, 1);
        check("t2_row_cnt", row_cnt, 2);
        idle(1);
        check("t2_row_cnt_clr", row_cnt, 0);
        check("t2_frame_done_off", frame_done, 0);

        // Same frame without ReLU
        relu_en = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFD, 1'b1);
        check("t3_flag", wr_data_act_flag, 16'h0012);
        check("t3_data", wr_data_act, 128'hFD00000500);
        check("t3_nz", row_nz_cnt, 2);
        check("t3_row_cnt", row_cnt, 1);
        idle(1);

        // Row completes while en=0; writes once en returns
        en = 1'b0;
        for (int k = 0; k < 16; k++) send_byte(8'(8'h20 + k), 1'b0);
        check("t4_pend_ready", in_ready, 0);
        check("t4_pend_strobe", wr_req_act, 0);
        base = strobe_cnt;
        idle(5);
        check("t4_pend_hold_ready", in_ready, 0);
        check("t4_pend_no_strobe", strobe_cnt - base, 0);
        en = 1'b1;
        step();
        check("t4_strobe", wr_req_act, 1);
        check("t4_data", wr_data_act, 128'h2F2E2D2C2B2A29282726252423222120);
        check("t4_row_cnt", row_cnt, 1);
        check("t4_ready_back", in_ready, 1);
        idle(3);
        check("t4_one_strobe", strobe_cnt - base, 1);

        // 48-byte frame after a clear
        clear = 1'b1;
        step();
        clear = 1'b0;
        ns = 0;
        for (int k = 1; k <= 48; k++) begin
            send_byte(8'(k), k == 48);
            if (wr_req_act) begin
                ns++;
                check("t5_row_cnt", row_cnt, ns);
                check("t5_frame_done", frame_done, ns == 3);
            end
        end
        check("t5_strobes", ns, 3);
        idle(1);
        check("t5_row_cnt_clr", row_cnt, 0);

        // Clear mid-row discards 7 bytes
        for (int k = 0; k < 7; k++) send_byte(8'(8'h30 + k), 1'b0);
        base = strobe_cnt;
        in_valid = 1'b0;
        clear = 1'b1;
        #1;
        check("t6_clear_ready", in_ready, 0);
        step();
        clear = 1'b0;
        for (int k = 0; k < 16; k++) send_byte(8'(8'h40 + k), 1'b0);
        check("t6_strobe", wr_req_act, 1);
        check("t6_data", wr_data_act, 128'h4F4E4D4C4B4A49484746454443424140);
        check("t6_row_cnt", row_cnt, 1);
        idle(2);
        check("t6_one_strobe", strobe_cnt - base, 1);

        // Reset mid-row discards 7 bytes
        for (int k = 0; k < 7; k++) send_byte(8'(8'h50 + k), 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        check("t7_rst_ready", in_ready, 0);
        check("t7_rst_row_cnt", row_cnt, 0);
        check("t7_rst_data", wr_data_act, 0);
        step();
        reset = 1'b1;
        base = strobe_cnt;
        for (int k = 0; k < 16; k++) send_byte(8'(8'h60 + k), 1'b0);
        check("t7_strobe", wr_req_act, 1);
        check("t7_data", wr_data_act, 128'h6F6E6D6C6B6A69686766656463626160);
        check("t7_row_cnt", row_cnt, 1);
        idle(2);
        check("t7_one_strobe", strobe_cnt - base, 1);

        // in_last on lane 15 yields exactly one row
        base = strobe_cnt;
        for (int k = 0; k < 16; k++) send_byte(8'(8'h70 + k), k == 15);
        check("t8_frame_done", frame_done, 1);
        check("t8_row_cnt", row_cnt, 2);
        idle(4);
        check("t8_one_strobe", strobe_cnt - base, 1);
        check("strobe_pair_equal", strobe_neq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
